// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sharing of one regfile read and write port among NREQ requesters,
// with a zero-fill sequencer that runs after reset before any request is granted.
module regfile_port_arbiter #(
  parameter int N = 16,
  parameter int WIDTH = 32,
  parameter int NREQ = 2,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      rd_valid,
  input  logic [NREQ*AW-1:0]   rd_addr,
  output logic [NREQ-1:0]      rd_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WIDTH-1:0]     rsp_data,
  input  logic [NREQ-1:0]      wr_valid,
  input  logic [NREQ*AW-1:0]   wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]      wr_ready,
  output logic                 init_done,
  output logic [AW-1:0]        R_addr,
  output logic                 R_en,
  input  logic [WIDTH-1:0]     R_data,
  output logic [AW-1:0]        W_addr,
  output logic                 W_en,
  output logic [WIDTH-1:0]     W_data
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic init_done_q, init_done_d;
  logic [PW:0] rd_pick, wr_pick;
  logic [PW-1:0] rd_win, wr_win;
  logic run, rd_any, wr_any;

  // Returns {found, index}; the lowest offset from the pointer wins.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] v, input logic [PW-1:0] p);
    logic [PW:0] r;
    int j;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NREQ) j -= NREQ;
      if (v[j]) r = {1'b1, PW'(j)};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] w);
    return (w == PW'(NREQ - 1)) ? '0 : w + PW'(1);
  endfunction

  assign run = state_q == RUN;
  assign rd_pick = rr_pick(rd_valid, rd_ptr_q);
  assign wr_pick = rr_pick(wr_valid, wr_ptr_q);
  assign rd_any = run & rd_pick[PW];
  assign wr_any = run & wr_pick[PW];
  assign rd_win = rd_pick[PW-1:0];
  assign wr_win = wr_pick[PW-1:0];
  assign rd_ready = rd_any ? NREQ'(1) << rd_win : '0;
  assign wr_ready = wr_any ? NREQ'(1) << wr_win : '0;
  assign R_en = rd_any;
  assign R_addr = rd_any ? rd_addr[int'(rd_win)*AW +: AW] : '0;
  assign W_en = !run | wr_any;
  assign W_addr = !run ? init_cnt_q : wr_any ? wr_addr[int'(wr_win)*AW +: AW] : '0;
  assign W_data = wr_any ? wr_data[int'(wr_win)*WIDTH +: WIDTH] : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign init_done = init_done_q;

  always_comb begin
    state_d = state_q;
    init_cnt_d = init_cnt_q;
    init_done_d = init_done_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rsp_valid_d = '0;
    rsp_data_d = rsp_data_q;
    if (!run) begin
      init_cnt_d = init_cnt_q + AW'(1);
      if (init_cnt_q == AW'(N - 1)) begin
        state_d = RUN;
        init_done_d = 1'b1;
        init_cnt_d = '0;
      end
    end
    if (rd_any) begin
      rd_ptr_d = nxt(rd_win);
      rsp_valid_d = rd_ready;
      rsp_data_d = R_data;
    end
    if (wr_any) wr_ptr_d = nxt(wr_win);
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= INIT;
      init_cnt_q <= '0;
      init_done_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      init_cnt_q <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed vector table plus reset/zero-fill sequences against a behavioural regfile.
module tb_regfile_port_arbiter;
  localparam int N = 16, WIDTH = 32, NREQ = 2, AW = 4, NV = 21;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] rd_valid, rd_ready, rsp_valid, wr_valid, wr_ready;
  logic [NREQ*AW-1:0] rd_addr, wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rsp_data, R_data, W_data;
  logic [AW-1:0] R_addr, W_addr;
  logic init_done, R_en, W_en;
  logic [WIDTH-1:0] regs [N];
  int n_cmp = 0, n_err = 0;

  regfile_port_arbiter #(.N(N), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .init_done(init_done),
    .R_addr(R_addr), .R_en(R_en), .R_data(R_data),
    .W_addr(W_addr), .W_en(W_en), .W_data(W_data)
  );

  always #5 clk = ~clk;
  assign R_data = regs[R_addr];
  always @(posedge clk) if (W_en) regs[W_addr] <= W_data;

  typedef struct {
    logic [1:0] rv; logic [3:0] ra0, ra1;
    logic [1:0] wv; logic [3:0] wa0, wa1; logic [31:0] wd0, wd1;
    logic [1:0] err, ewr; logic [3:0] eraddr, ewaddr; logic [31:0] ewdata;
    logic [1:0] ersp; logic [31:0] edata;
  } vec_t;
  vec_t tv [NV];

  function automatic vec_t mk(input logic [1:0] rv, input logic [3:0] ra0, ra1,
                              input logic [1:0] wv, input logic [3:0] wa0, wa1, input logic [31:0] wd0, wd1,
                              input logic [1:0] err, ewr, input logic [3:0] eraddr, ewaddr,
                              input logic [31:0] ewdata, input logic [1:0] ersp, input logic [31:0] edata);
    vec_t v;
    v.rv = rv; v.ra0 = ra0; v.ra1 = ra1; v.wv = wv; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.err = err; v.ewr = ewr; v.eraddr = eraddr; v.ewaddr = ewaddr; v.ewdata = ewdata;
    v.ersp = ersp; v.edata = edata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a negedge with rst_n just released; walks the 16 zero-fill cycles.
  task automatic init_phase();
    for (int c = 0; c < N; c++) begin
      #1;
      chk($sformatf("init%0d_W_en", c), 64'(W_en), 64'd1);
      chk($sformatf("init%0d_W_addr", c), 64'(W_addr), 64'(c));
      chk($sformatf("init%0d_W_data", c), 64'(W_data), 64'd0);
      chk($sformatf("init%0d_R_en", c), 64'(R_en), 64'd0);
      chk($sformatf("init%0d_rd_ready", c), 64'(rd_ready), 64'd0);
      chk($sformatf("init%0d_wr_ready", c), 64'(wr_ready), 64'd0);
      chk($sformatf("init%0d_init_done", c), 64'(init_done), 64'd0);
      @(negedge clk);
    end
    rd_valid = '0;
    wr_valid = '0;
    #1;
    chk("init_done_set", 64'(init_done), 64'd1);
    chk("idle_W_en", 64'(W_en), 64'd0);
    chk("idle_rd_ready", 64'(rd_ready), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] <= 32'hA5A5_0000 | 32'(i);
    rd_valid = '0; wr_valid = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    tv[0]  = mk(2'b01, 5, 0, 2'b00, 0, 0, 0, 0,                     2'b01, 2'b00, 5, 0, 0,           2'b01, 32'h0);
    tv[1]  = mk(2'b00, 0, 0, 2'b01, 3, 0, 32'hDEADBEEF, 0,          2'b00, 2'b01, 0, 3, 32'hDEADBEEF, 2'b00, 32'h0);
    tv[2]  = mk(2'b10, 0, 3, 2'b00, 0, 0, 0, 0,                     2'b10, 2'b00, 3, 0, 0,           2'b10, 32'hDEADBEEF);
    tv[3]  = mk(2'b00, 0, 0, 2'b11, 1, 2, 32'h11110001, 32'h22220002, 2'b00, 2'b10, 0, 2, 32'h22220002, 2'b00, 32'hDEADBEEF);
    tv[4]  = mk(2'b00, 0, 0, 2'b11, 1, 2, 32'h11110001, 32'h22220002, 2'b00, 2'b01, 0, 1, 32'h11110001, 2'b00, 32'hDEADBEEF);
    tv[5]  = mk(2'b00, 0, 0, 2'b10, 0, 7, 0, 32'h11,                2'b00, 2'b10, 0, 7, 32'h11,       2'b00, 32'hDEADBEEF);
    tv[6]  = mk(2'b11, 1, 2, 2'b00, 0, 0, 0, 0,                     2'b01, 2'b00, 1, 0, 0,           2'b01, 32'h11110001);
    tv[7]  = mk(2'b11, 1, 2, 2'b00, 0, 0, 0, 0,                     2'b10, 2'b00, 2, 0, 0,           2'b10, 32'h22220002);
    tv[8]  = mk(2'b11, 1, 2, 2'b00, 0, 0, 0, 0,                     2'b01, 2'b00, 1, 0, 0,           2'b01, 32'h11110001);
    tv[9]  = mk(2'b11, 1, 2, 2'b00, 0, 0, 0, 0,                     2'b10, 2'b00, 2, 0, 0,           2'b10, 32'h22220002);
    tv[10] = mk(2'b10, 0, 7, 2'b01, 7, 0, 32'h55, 0,                2'b10, 2'b01, 7, 7, 32'h55,       2'b10, 32'h11);
    tv[11] = mk(2'b01, 7, 0, 2'b00, 0, 0, 0, 0,                     2'b01, 2'b00, 7, 0, 0,           2'b01, 32'h55);
    tv[12] = mk(2'b10, 0, 4, 2'b00, 0, 0, 0, 0,                     2'b10, 2'b00, 4, 0, 0,           2'b10, 32'h0);
    tv[13] = mk(2'b10, 0, 4, 2'b00, 0, 0, 0, 0,                     2'b10, 2'b00, 4, 0, 0,           2'b10, 32'h0);
    tv[14] = mk(2'b10, 0, 4, 2'b00, 0, 0, 0, 0,                     2'b10, 2'b00, 4, 0, 0,           2'b10, 32'h0);
    tv[15] = mk(2'b11, 3, 4, 2'b00, 0, 0, 0, 0,                     2'b01, 2'b00, 3, 0, 0,           2'b01, 32'hDEADBEEF);
    tv[16] = mk(2'b01, 2, 0, 2'b00, 0, 0, 0, 0,                     2'b01, 2'b00, 2, 0, 0,           2'b01, 32'h22220002);
    tv[17] = mk(2'b11, 1, 7, 2'b00, 0, 0, 0, 0,                     2'b10, 2'b00, 7, 0, 0,           2'b10, 32'h55);
    tv[18] = mk(2'b00, 0, 0, 2'b11, 9, 10, 32'h99, 32'hAA,          2'b00, 2'b10, 0, 10, 32'hAA,      2'b00, 32'h55);
    tv[19] = mk(2'b00, 0, 0, 2'b00, 0, 0, 0, 0,                     2'b00, 2'b00, 0, 0, 0,           2'b00, 32'h55);
    tv[20] = mk(2'b11, 10, 9, 2'b00, 0, 0, 0, 0,                    2'b01, 2'b00, 10, 0, 0,          2'b01, 32'hAA);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_W_addr", 64'(W_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_valid = '1;
    wr_valid = '1;
    init_phase();

    for (int i = 0; i < NV; i++) begin
      rd_valid = tv[i].rv; rd_addr = {tv[i].ra1, tv[i].ra0};
      wr_valid = tv[i].wv; wr_addr = {tv[i].wa1, tv[i].wa0}; wr_data = {tv[i].wd1, tv[i].wd0};
      #1;
      chk($sformatf("v%0d_rd_ready", i), 64'(rd_ready), 64'(tv[i].err));
      chk($sformatf("v%0d_wr_ready", i), 64'(wr_ready), 64'(tv[i].ewr));
      chk($sformatf("v%0d_R_en", i), 64'(R_en), 64'(|tv[i].err));
      chk($sformatf("v%0d_R_addr", i), 64'(R_addr), 64'(tv[i].eraddr));
      chk($sformatf("v%0d_W_en", i), 64'(W_en), 64'(|tv[i].ewr));
      if (tv[i].ewr != 2'b00) begin
        chk($sformatf("v%0d_W_addr", i), 64'(W_addr), 64'(tv[i].ewaddr));
        chk($sformatf("v%0d_W_data", i), 64'(W_data), 64'(tv[i].ewdata));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(tv[i].ersp));
      chk($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(tv[i].edata));
      @(negedge clk);
    end

    // Mid-run reset with a response in flight.
    rd_valid = 2'b01; rd_addr = {4'd0, 4'd3}; wr_valid = '0;
    @(posedge clk);
    #1;
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("pre_rst_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("mid_rst_init_done", 64'(init_done), 64'd0);
    chk("mid_rst_W_en", 64'(W_en), 64'd1);
    chk("mid_rst_W_addr", 64'(W_addr), 64'd0);
    chk("mid_rst_rd_ready", 64'(rd_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_valid = '1;
    wr_valid = '1;
    init_phase();

    // Pointer back at requester 0 and address 3 zero-filled again.
    rd_valid = 2'b11; rd_addr = {4'd5, 4'd3};
    #1;
    chk("post_rst_rd_ready", 64'(rd_ready), 64'b01);
    chk("post_rst_R_addr", 64'(R_addr), 64'd3);
    @(posedge clk);
    #1;
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("post_rst_rsp_data", 64'(rsp_data), 64'd0);
    @(negedge clk);
    rd_valid = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single read port and single write port of the `regfile` block between NREQ requesters.
- Read and write ports are arbitrated independently, each round-robin, with a valid/ready handshake per requester.
- After reset, a sequencer zero-fills every register before any request is accepted.
- Sits between the requester logic and the `regfile` instance; it alone drives the regfile's R_*/W_* pins.

Parameters:
- N, 16, number of registers in the attached regfile; ADDR_WIDTH = clog2(N).
- WIDTH, 32, data width of each register.
- NREQ, 2, number of requesters; NREQ >= 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- rd_valid  input  NREQ  per-requester read request.
- rd_addr  input  NREQ*ADDR_WIDTH  read address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_ready  output  NREQ  read grant, one-hot or zero.
- rsp_valid  output  NREQ  read response valid, one-hot or zero.
- rsp_data  output  WIDTH  read response data; shared by all requesters and qualified by rsp_valid.
- wr_valid  input  NREQ  per-requester write request.
- wr_addr  input  NREQ*ADDR_WIDTH  write address, sliced as for rd_addr.
- wr_data  input  NREQ*WIDTH  write data; slice [i*WIDTH +: WIDTH].
- wr_ready  output  NREQ  write grant, one-hot or zero.
- init_done  output  1  high once the zero-fill has completed.
- R_addr  output  ADDR_WIDTH  to regfile.
- R_en  output  1  to regfile.
- R_data  input  WIDTH  from regfile; asynchronous read of regs[R_addr].
- W_addr  output  ADDR_WIDTH  to regfile.
- W_en  output  1  to regfile.
- W_data  output  WIDTH  to regfile.

Behaviour:
- Reset is synchronous: rst_n=0 at a rising edge forces the following register values:
  - state=INIT, init_cnt=0;
  - both round-robin pointers = 0 (requester 0 has highest priority);
  - rsp_valid=0, rsp_data=0, init_done=0.
- Reset asserted mid-operation behaves identically. Any in-flight response is dropped and the zero-fill restarts from address 0.
- FSM has two states, INIT and RUN.
- INIT state:
  - Outputs: W_en=1, W_addr=init_cnt, W_data=0, R_en=0; all rd_ready=0 and wr_ready=0.
  - Each cycle: init_cnt increments.
  - Transition: when init_cnt==N-1, go to RUN and set init_done=1 on the same edge.
  - INIT lasts exactly N cycles after reset deasserts.
- RUN state, read arbitration:
  - Winner is the first requester i with rd_valid[i]=1, searching from rd_ptr upward modulo NREQ.
  - rd_ready[winner]=1, combinationally from rd_valid and the pointer.
  - R_en=1, R_addr=rd_addr[winner]. With no requests, R_en=0, R_addr=0, rd_ready=0.
  - A transfer occurs when rd_valid[i] & rd_ready[i] are both high at the edge.
  - On transfer: rd_ptr <= (winner+1) mod NREQ; rsp_data <= R_data; rsp_valid <= one-hot(winner).
  - Without a transfer: rsp_valid <= 0 and rsp_data holds.
- Read latency is 1 cycle: response visible the cycle after the handshake.
- There is no response backpressure; a requester must sample rsp_data while its rsp_valid bit is high. Back-to-back reads give one response per cycle.
- RUN state, write arbitration:
  - Independent round-robin pointer wr_ptr, same search rule as reads.
  - W_en=1, W_addr=wr_addr[winner], W_data=wr_data[winner].
  - On transfer: wr_ptr <= (winner+1) mod NREQ. With no requests, W_en=0.
- Simultaneous read and write:
  - One read and one write may complete in the same cycle, from the same or different requesters.
  - Same address in the same cycle: the read returns the old value (write-after-read); the new value is visible to reads from the next cycle.
- Pointers only advance on a transfer, so an idle requester never steals priority.
- A requester holding valid is granted within NREQ cycles.
- A requester may change its address while not granted; the arbiter does not latch request fields.
- Addresses >= N (only possible when N is not a power of 2) are not checked; the resulting behaviour is unspecified.

Test Plan:
- Reset, N=16: hold rst_n=0 for 2 cycles, release → 16 cycles with W_en=1, W_addr 0..15, W_data=0, all ready=0; then init_done=1. A read of address 5 returns 0.
- Write from requester 0 (addr 3, 0xDEADBEEF), then read of addr 3 from requester 1 → wr_ready[0]=1 in the write cycle. One cycle after the read handshake: rsp_valid=2'b10, rsp_data=0xDEADBEEF.
- Both requesters hold rd_valid=1 for 4 cycles, addresses 1 and 2 → grants alternate 0,1,0,1. rsp_valid sequence 01,10,01,10 (each one cycle after its handshake) with data regs[1], regs[2] alternating.
- Same cycle: requester 0 writes 0x55 to addr 7, which held 0x11, while requester 1 reads addr 7 → rsp_data=0x11; a read of addr 7 on the next cycle returns 0x55.
- Only requester 1 requests for 3 cycles, then both request → requester 1 is granted every cycle. On the first contended cycle requester 0 wins, because rd_ptr=0 after each requester-1 grant.
- Assert rst_n=0 for one cycle during RUN with a read in flight → next cycle rsp_valid=0, state=INIT, W_addr=0, and all ready outputs low until init_done rises again.
